irq_priority_ctrl: RTL and testbench

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_prio_arbiter.sv | 39 +++
 rtl/irq_priority_ctrl.sv | 153 +++++++++++++++
 tb/tb_irq_priority_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt priority controller.
// Holds the controller FSM state encoding and the default source/priority widths.
package irq_pkg;

    localparam int IRQ_NUM_SRC_DEF = 32;
    localparam int IRQ_PRIO_W_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_arbiter.sv
// Combinational priority pick over the eligible sources.
// Highest priority wins; equal priorities resolve to the lowest index.
module irq_prio_arbiter
    import irq_pkg::*;
#(
    parameter  int NUM_SRC = IRQ_NUM_SRC_DEF,
    parameter  int PRIO_W  = IRQ_PRIO_W_DEF,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]        elig_i,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
    output logic                      any_o,
    output logic [ID_W-1:0]           win_id_o,
    output logic [PRIO_W-1:0]         win_level_o
);

    logic              found;
    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_lvl;

    always_comb begin
        found    = 1'b0;
        best_id  = '0;
        best_lvl = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // strict compare keeps the earlier (lower) index on a tie
            if (elig_i[i] && (!found || (prio_i[i*PRIO_W +: PRIO_W] > best_lvl))) begin
                found    = 1'b1;
                best_id  = ID_W'(i);
                best_lvl = prio_i[i*PRIO_W +: PRIO_W];
            end
        end
    end

    assign any_o       = found;
    assign win_id_o    = best_id;
    assign win_level_o = best_lvl;

endmodule

// File: rtl/irq_priority_ctrl.sv
// Priority interrupt controller: edge/level capture, masked arbitration, offer/claim/complete.
// Define IRQ_PRIORITY_CTRL_SYNC_EN to put a 2-flop synchronizer on every irq_in bit.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | nothing offered; waiting for an eligible source
//   OFFER   | irq_valid high; id/level follow the current winner each cycle
//   SERVICE | claimed; irq_id frozen until a matching irq_complete
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter  int NUM_SRC = IRQ_NUM_SRC_DEF,
    parameter  int PRIO_W  = IRQ_PRIO_W_DEF,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        irq_in,
    input  logic [NUM_SRC-1:0]        edge_mode,
    input  logic [NUM_SRC-1:0]        irq_en,
    input  logic [NUM_SRC*PRIO_W-1:0] irq_prio,
    input  logic [PRIO_W-1:0]         prio_threshold,
    output logic                      irq_valid,
    output logic [ID_W-1:0]           irq_id,
    output logic [PRIO_W-1:0]         irq_level,
    input  logic                      irq_claim,
    input  logic                      irq_complete,
    input  logic [ID_W-1:0]           irq_complete_id,
    output logic [NUM_SRC-1:0]        pending
);

    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] elig;

    logic               arb_any;
    logic [ID_W-1:0]    arb_id;
    logic [PRIO_W-1:0]  arb_level;

    irq_state_e         state_q;
    logic               valid_q;
    logic [ID_W-1:0]    id_q;
    logic [PRIO_W-1:0]  level_q;

`ifdef IRQ_PRIORITY_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    // A claim clears only the edge latch of the id being accepted; a fresh rise in the same cycle wins.
    always_comb begin
        rise = irq_s & ~prev_q;
        clr  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = (state_q == OFFER) && irq_claim && (id_q == ID_W'(i));
        end
        pending_d = (edge_mode & ((pending_q & ~clr) | rise)) | (~edge_mode & irq_s);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= irq_s;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = pending_q[i] && irq_en[i] &&
                      (irq_prio[i*PRIO_W +: PRIO_W] > prio_threshold);
        end
    end

    irq_prio_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arb (
        .elig_i      (elig),
        .prio_i      (irq_prio),
        .any_o       (arb_any),
        .win_id_o    (arb_id),
        .win_level_o (arb_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            level_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        state_q <= OFFER;
                        valid_q <= 1'b1;
                        id_q    <= arb_id;
                        level_q <= arb_level;
                    end
                end
                OFFER: begin
                    if (irq_claim) begin
                        state_q <= SERVICE;
                        valid_q <= 1'b0;
                    end else if (arb_any) begin
                        id_q    <= arb_id;
                        level_q <= arb_level;
                    end else begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (irq_complete && (irq_complete_id == id_q)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid = valid_q;
    assign irq_id    = id_q;
    assign irq_level = level_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the controller.
module tb_irq_priority_ctrl;

    localparam int NS = 32;
    localparam int PW = 3;
    localparam int IW = 5;
`ifdef IRQ_PRIORITY_CTRL_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NS-1:0]    irq_in;
    logic [NS-1:0]    edge_mode;
    logic [NS-1:0]    irq_en;
    logic [NS*PW-1:0] irq_prio;
    logic [PW-1:0]    prio_threshold;
    logic             irq_valid;
    logic [IW-1:0]    irq_id;
    logic [PW-1:0]    irq_level;
    logic             irq_claim;
    logic             irq_complete;
    logic [IW-1:0]    irq_complete_id;
    logic [NS-1:0]    pending;

    int n_total = 0;
    int n_bad   = 0;

    // behavioural model state
    bit [NS-1:0] m_pend;
    bit [NS-1:0] m_prev;
    bit [NS-1:0] m_s1;
    bit [NS-1:0] m_s2;
    bit          m_offer;
    bit          m_busy;
    int          m_id;
    int          m_lvl;

    irq_priority_ctrl #(.NUM_SRC(NS), .PRIO_W(PW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .irq_in          (irq_in),
        .edge_mode       (edge_mode),
        .irq_en          (irq_en),
        .irq_prio        (irq_prio),
        .prio_threshold  (prio_threshold),
        .irq_valid       (irq_valid),
        .irq_id          (irq_id),
        .irq_level       (irq_level),
        .irq_claim       (irq_claim),
        .irq_complete    (irq_complete),
        .irq_complete_id (irq_complete_id),
        .pending         (pending)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_prev  = '0;
        m_s1    = '0;
        m_s2    = '0;
        m_offer = 1'b0;
        m_busy  = 1'b0;
        m_id    = 0;
        m_lvl   = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit [NS-1:0] in_now;
        bit [NS-1:0] rise;
        bit [NS-1:0] nxt;
        int best, wid, wlvl, pr, score, clr_id;
        bit claim_hit;
        if (SYNC_LAT > 0) begin
            in_now = m_s2;
            m_s2   = m_s1;
            m_s1   = irq_in;
        end else begin
            in_now = irq_in;
        end
        rise = in_now & ~m_prev;
        best = -1;
        wid  = 0;
        wlvl = 0;
        for (int i = 0; i < NS; i++) begin
            pr = int'(irq_prio[i*PW +: PW]);
            if (m_pend[i] && irq_en[i] && pr > int'(prio_threshold)) begin
                score = pr * NS + (NS - 1 - i);
                if (score > best) begin
                    best = score;
                    wid  = i;
                    wlvl = pr;
                end
            end
        end
        claim_hit = m_offer && irq_claim;
        clr_id    = m_id;
        if (claim_hit) begin
            m_offer = 1'b0;
            m_busy  = 1'b1;
        end else if (m_busy) begin
            if (irq_complete && int'(irq_complete_id) == m_id) m_busy = 1'b0;
        end else if (best >= 0) begin
            m_offer = 1'b1;
            m_id    = wid;
            m_lvl   = wlvl;
        end else begin
            m_offer = 1'b0;
        end
        for (int i = 0; i < NS; i++) begin
            if (edge_mode[i])
                nxt[i] = (m_pend[i] && !(claim_hit && clr_id == i)) || rise[i];
            else
                nxt[i] = in_now[i];
        end
        m_pend = nxt;
        m_prev = in_now;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk_eq("valid",   64'(irq_valid), 64'(m_offer));
        chk_eq("id",      64'(irq_id),    64'(m_id));
        chk_eq("level",   64'(irq_level), 64'(m_lvl));
        chk_eq("pending", 64'(pending),   64'(m_pend));
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        irq_in          = '0;
        edge_mode       = '0;
        irq_en          = '1;
        irq_prio        = '0;
        prio_threshold  = '0;
        irq_claim       = 1'b0;
        irq_complete    = 1'b0;
        irq_complete_id = '0;
        model_reset();
        #1;
        chk_eq("rst_valid",   64'(irq_valid), 64'(0));
        chk_eq("rst_id",      64'(irq_id),    64'(0));
        chk_eq("rst_level",   64'(irq_level), 64'(0));
        chk_eq("rst_pending", 64'(pending),   64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_prio(input int src, input int p);
        irq_prio[src*PW +: PW] = PW'(p);
    endtask

    // One-cycle pulse on the masked lines, then wait until it has reached the capture stage.
    task automatic pulse(input logic [NS-1:0] mask);
        irq_in = irq_in | mask;
        cycle();
        irq_in = irq_in & ~mask;
        repeat (SYNC_LAT) cycle();
    endtask

    task automatic claim_once();
        irq_claim = 1'b1;
        cycle();
        irq_claim = 1'b0;
    endtask

    task automatic complete_once(input int id);
        irq_complete    = 1'b1;
        irq_complete_id = IW'(id);
        cycle();
        irq_complete    = 1'b0;
    endtask

    initial begin
        // edge source 5 offered two cycles after its pulse, cleared on claim
        do_reset();
        edge_mode[5] = 1'b1;
        set_prio(5, 3);
        pulse(32'h1 << 5);
        cycle();
        chk_eq("e5_valid", 64'(irq_valid), 64'(1));
        chk_eq("e5_id",    64'(irq_id),    64'(5));
        chk_eq("e5_level", 64'(irq_level), 64'(3));
        claim_once();
        chk_eq("e5_claim_valid", 64'(irq_valid),  64'(0));
        chk_eq("e5_claim_pend",  64'(pending[5]), 64'(0));
        complete_once(5);
        chk_eq("e5_done_valid", 64'(irq_valid), 64'(0));

        // level tie: lowest index wins, re-offered while still asserted
        do_reset();
        set_prio(2, 4);
        set_prio(7, 4);
        irq_in[2] = 1'b1;
        irq_in[7] = 1'b1;
        repeat (SYNC_LAT) cycle();
        cycle();
        cycle();
        chk_eq("tie_id",    64'(irq_id),    64'(2));
        chk_eq("tie_valid", 64'(irq_valid), 64'(1));
        claim_once();
        complete_once(2);
        chk_eq("tie_idle", 64'(irq_valid), 64'(0));
        cycle();
        chk_eq("tie_reoffer_valid", 64'(irq_valid), 64'(1));
        chk_eq("tie_reoffer_id",    64'(irq_id),    64'(2));

        // threshold filtering
        do_reset();
        set_prio(9, 2);
        set_prio(1, 6);
        prio_threshold = 3'd5;
        irq_in[9] = 1'b1;
        irq_in[1] = 1'b1;
        repeat (SYNC_LAT) cycle();
        cycle();
        cycle();
        chk_eq("thr5_id",    64'(irq_id),    64'(1));
        chk_eq("thr5_level", 64'(irq_level), 64'(6));
        prio_threshold = 3'd6;
        cycle();
        chk_eq("thr6_valid", 64'(irq_valid), 64'(0));
        prio_threshold = 3'd1;
        cycle();
        cycle();
        chk_eq("thr1_id", 64'(irq_id), 64'(1));

        // wrong complete id ignored; queued edge offered one cycle after the idle
        do_reset();
        edge_mode[4]  = 1'b1;
        edge_mode[10] = 1'b1;
        set_prio(4, 5);
        set_prio(10, 1);
        pulse(32'h1 << 4);
        cycle();
        chk_eq("svc_id", 64'(irq_id), 64'(4));
        claim_once();
        pulse(32'h1 << 10);
        cycle();
        chk_eq("svc_no_offer", 64'(irq_valid), 64'(0));
        complete_once(3);
        chk_eq("svc_bad_cmp_valid", 64'(irq_valid), 64'(0));
        chk_eq("svc_bad_cmp_id",    64'(irq_id),    64'(4));
        complete_once(4);
        chk_eq("svc_done_idle", 64'(irq_valid), 64'(0));
        cycle();
        chk_eq("svc_queued_valid", 64'(irq_valid), 64'(1));
        chk_eq("svc_queued_id",    64'(irq_id),    64'(10));

        // re-pulse during claim: set wins over the claim clear
        do_reset();
        edge_mode[0] = 1'b1;
        set_prio(0, 7);
        pulse(32'h1);
        cycle();
        chk_eq("rp_offer_id", 64'(irq_id), 64'(0));
        irq_in[0] = 1'b1;
        repeat (SYNC_LAT) cycle();
        claim_once();
        irq_in[0] = 1'b0;
        chk_eq("rp_pend_kept", 64'(pending[0]), 64'(1));
        complete_once(0);
        cycle();
        chk_eq("rp_reoffer_valid", 64'(irq_valid), 64'(1));
        chk_eq("rp_reoffer_id",    64'(irq_id),    64'(0));

        // async reset in SERVICE with three queued edges
        do_reset();
        edge_mode[4]  = 1'b1;
        edge_mode[11] = 1'b1;
        edge_mode[12] = 1'b1;
        edge_mode[13] = 1'b1;
        set_prio(4, 3);
        set_prio(11, 3);
        set_prio(12, 3);
        set_prio(13, 3);
        pulse(32'h1 << 4);
        cycle();
        claim_once();
        pulse(32'h7 << 11);
        cycle();
        chk_eq("ar_pend3", 64'(pending[13:11]), 64'(7));
        chk_eq("ar_svc_id", 64'(irq_id), 64'(4));
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_eq("ar_valid",   64'(irq_valid), 64'(0));
        chk_eq("ar_id",      64'(irq_id),    64'(0));
        chk_eq("ar_level",   64'(irq_level), 64'(0));
        chk_eq("ar_pending", 64'(pending),   64'(0));

        // randomized traffic against the model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            edge_mode = $urandom;
            irq_en    = $urandom | $urandom;
            for (int i = 0; i < NS; i++) irq_prio[i*PW +: PW] = PW'($urandom);
            prio_threshold = PW'($urandom_range(0, 2));
            for (int c = 0; c < 400; c++) begin
                if (c % 97 == 96) prio_threshold = PW'($urandom_range(0, 4));
                irq_in          = irq_in ^ ($urandom & $urandom & $urandom);
                irq_claim       = ($urandom_range(0, 3) == 0);
                irq_complete    = ($urandom_range(0, 3) == 0);
                irq_complete_id = ($urandom_range(0, 1) == 0) ? IW'(m_id) : IW'($urandom);
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
